// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris display path: paint FSM encoding, colour
// format, screen and cell geometry, palette constants and a clip helper.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIN  = 2'd2
  } paint_state_t;

  localparam int COLOR_W       = 9;
  localparam int SCR_W_DEFAULT = 640;
  localparam int SCR_H_DEFAULT = 480;
  localparam int CELL_W        = 64;
  localparam int CELL_H        = 24;

  localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 9'b111_000_111;
  localparam logic [COLOR_W-1:0] COLOR_WHITE   = 9'b111_111_111;

  // Sums carry one extra bit, so a set top bit is a wrapped coordinate.
  function automatic logic on_screen(input logic [10:0] sx, input logic [9:0] sy,
                                     input int scr_w, input int scr_h);
    logic x_ok;
    logic y_ok;
    x_ok = !sx[10] && ({21'd0, sx} < 32'(scr_w));
    y_ok = !sy[9]  && ({22'd0, sy} < 32'(scr_h));
    return x_ok && y_ok;
  endfunction

endpackage

// File: rtl/box_scan_counter.sv
// Raster column/row counter for one box; last flags the final pixel position.
module box_scan_counter
  import tetris_pkg::*;
#(
  parameter int BOX_W = CELL_W,
  parameter int BOX_H = CELL_H
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       last
);

  localparam logic [9:0] COL_MAX = 10'(BOX_W - 1);
  localparam logic [8:0] ROW_MAX = 9'(BOX_H - 1);

  // Final pixel of the box: both counters at their maximum.
  always_comb begin
    last = (col == COL_MAX) && (row == ROW_MAX);
  end

  // Column is the inner loop, row the outer; both wrap to zero after the last pixel.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      col <= 10'd0;
      row <= 9'd0;
    end else if (step) begin
      if (col == COL_MAX) begin
        col <= 10'd0;
        if (row == ROW_MAX) begin
          row <= 9'd0;
        end else begin
          row <= row + 9'd1;
        end
      end else begin
        col <= col + 10'd1;
      end
    end else if (clear) begin
      col <= 10'd0;
      row <= 9'd0;
    end else begin
      col <= col;
      row <= row;
    end
  end

endmodule

// File: rtl/cell_painter.sv
// Paints one solid BOX_W x BOX_H box as a raster stream of clipped pixel writes.
// Define CELL_PAINTER_BORDER_EN to draw the outermost ring in BORDER_COLOR.
module cell_painter
  import tetris_pkg::*;
#(
  parameter int                 BOX_W        = CELL_W,
  parameter int                 BOX_H        = CELL_H,
  parameter int                 SCR_W        = SCR_W_DEFAULT,
  parameter int                 SCR_H        = SCR_H_DEFAULT,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = 9'b000_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [8:0] color,
  output logic       busy,
  output logic       done,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic [8:0] pix_color,
  output logic       pix_we
);

  if (BOX_W < 1 || BOX_W > 1023 || BOX_H < 1 || BOX_H > 511) begin : g_bad_box
    $error("cell_painter: BOX_W/BOX_H out of range");
  end

  paint_state_t       state;
  logic [9:0]         lat_x;
  logic [8:0]         lat_y;
  logic [COLOR_W-1:0] lat_color;
  logic               last_sent;

  logic [9:0]         col;
  logic [8:0]         row;
  logic               last;

  logic               accept;
  logic               emit;
  logic               clear_cnt;
  logic [9:0]         src_x;
  logic [8:0]         src_y;
  logic [COLOR_W-1:0] src_color;
  logic [10:0]        sum_x;
  logic [9:0]         sum_y;
  logic               visible;
  logic [COLOR_W-1:0] pixel_color;

`ifdef CELL_PAINTER_BORDER_EN
  localparam logic [9:0] COL_LAST = 10'(BOX_W - 1);
  localparam logic [8:0] ROW_LAST = 9'(BOX_H - 1);
`endif

  box_scan_counter #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clear    (clear_cnt),
    .step     (emit),
    .col      (col),
    .row      (row),
    .last     (last)
  );

  // The accepting edge already emits pixel (0,0) from the raw inputs, so the
  // first write is visible the cycle right after start is sampled.
  always_comb begin
    accept      = 1'b0;
    src_x       = lat_x;
    src_y       = lat_y;
    src_color   = lat_color;
    if (start && (state == IDLE || state == FIN)) begin
      accept    = 1'b1;
      src_x     = x0;
      src_y     = y0;
      src_color = color;
    end else begin
      accept    = 1'b0;
    end
    emit      = accept || (state == FILL && !last_sent);
    clear_cnt = (state != FILL) && !accept;
    sum_x     = {1'b0, src_x} + {1'b0, col};
    sum_y     = {1'b0, src_y} + {1'b0, row};
    visible   = on_screen(sum_x, sum_y, SCR_W, SCR_H);
`ifdef CELL_PAINTER_BORDER_EN
    if (col == 10'd0 || col == COL_LAST || row == 9'd0 || row == ROW_LAST) begin
      pixel_color = BORDER_COLOR;
    end else begin
      pixel_color = src_color;
    end
`else
    pixel_color = src_color;
`endif
  end

  // Paint FSM with registered status and pixel-write outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_we    <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 9'd0;
      pix_color <= 9'd0;
      lat_x     <= 10'd0;
      lat_y     <= 9'd0;
      lat_color <= 9'd0;
      last_sent <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (accept) begin
            state     <= FILL;
            busy      <= 1'b1;
            lat_x     <= x0;
            lat_y     <= y0;
            lat_color <= color;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        FILL: begin
          if (last_sent) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= FILL;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase

      // Clipped pixels still advance the scan; only the strobe is suppressed.
      if (emit) begin
        pix_we    <= visible;
        pix_x     <= sum_x[9:0];
        pix_y     <= sum_y[8:0];
        pix_color <= pixel_color;
        last_sent <= last;
      end else begin
        pix_we    <= 1'b0;
        last_sent <= 1'b0;
      end
    end
  end

endmodule
